spike_rate_encoder: RTL and testbench

Rate-coding front end for the LIF network. It converts eight 8-bit per-channel intensities into eight binary spike trains. Each train drives one first-layer neuron's `current` input. Rates are written through a valid/ready port into shadow registers and become active at the next window boundary, so the spike stream never carries a half-updated rate set.

---
 rtl/spike_rate_encoder.sv | 154 +++++++++++++++
 tb/tb_spike_rate_encoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_encoder.sv
// Eight-channel rate-coded spike generator with window-synchronous rate reload.
// Define SPIKE_ENC_POISSON_EN for LFSR-based stochastic encoding instead of phase accumulators.
`timescale 1ns/1ps
module spike_rate_encoder #(
    parameter int WINDOW_LEN = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_chan,
    input  logic [7:0] in_rate,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] spike_out,
    output logic       window_done,
    output logic       busy
);
    localparam int CW = $clog2(WINDOW_LEN);
    localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_LEN - 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
    typedef logic [7:0] byte_arr_t [8];

    state_t          state_q, state_d;
    byte_arr_t       shadow_q, shadow_d;
    byte_arr_t       rate_q, rate_d;
    logic [CW-1:0]   win_cnt_q, win_cnt_d;
    logic [7:0]      spike_q, spike_d;
    logic            wdone_q, wdone_d;
    logic [7:0]      spk_w;
    logic            last_w;
    logic            wr_en;
`ifdef SPIKE_ENC_POISSON_EN
    logic [15:0]     lfsr_q, lfsr_d;
    logic [14:0]     lfsr_rot;
`else
    byte_arr_t       acc_q, acc_d;
    logic [8:0]      sum_w [8];
`endif

    assign last_w      = (win_cnt_q == WIN_LAST);
    assign in_ready    = (state_q == S_IDLE) || !last_w;
    assign wr_en       = ena && in_valid && in_ready;
    assign busy        = (state_q == S_RUN);
    assign spike_out   = spike_q;
    assign window_done = wdone_q;

`ifdef SPIKE_ENC_POISSON_EN
    // Doubled low byte lets each channel take its rotated threshold as a plain slice.
    assign lfsr_rot = {lfsr_q[7:0], lfsr_q[7:1]};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_chan
`ifdef SPIKE_ENC_POISSON_EN
            assign spk_w[gi] = (rate_q[gi] > lfsr_rot[14-gi -: 8]);
`else
            assign sum_w[gi] = {1'b0, acc_q[gi]} + {1'b0, rate_q[gi]};
            assign spk_w[gi] = sum_w[gi][8];
`endif
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        rate_d    = rate_q;
        win_cnt_d = win_cnt_q;
        spike_d   = spike_q;
        wdone_d   = wdone_q;
`ifdef SPIKE_ENC_POISSON_EN
        lfsr_d    = lfsr_q;
`else
        acc_d     = acc_q;
`endif
        if (ena) begin
            wdone_d = 1'b0;
            if (wr_en) begin
                shadow_d[in_chan] = in_rate;
            end
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_d   = S_RUN;
                        rate_d    = shadow_q;
                        win_cnt_d = '0;
`ifndef SPIKE_ENC_POISSON_EN
                        acc_d     = '{default: '0};
`endif
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d   = S_IDLE;
                        spike_d   = '0;
                        win_cnt_d = '0;
`ifndef SPIKE_ENC_POISSON_EN
                        acc_d     = '{default: '0};
`endif
                    end else begin
                        spike_d = spk_w;
`ifdef SPIKE_ENC_POISSON_EN
                        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`else
                        for (int i = 0; i < 8; i++) begin
                            acc_d[i] = sum_w[i][7:0];
                        end
`endif
                        // Boundary edge still accumulates with the old rates; new set applies next edge.
                        if (last_w) begin
                            win_cnt_d = '0;
                            wdone_d   = 1'b1;
                            rate_d    = shadow_q;
                        end else begin
                            win_cnt_d = win_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shadow_q  <= '{default: '0};
            rate_q    <= '{default: '0};
            win_cnt_q <= '0;
            spike_q   <= '0;
            wdone_q   <= 1'b0;
`ifdef SPIKE_ENC_POISSON_EN
            lfsr_q    <= 16'hACE1;
`else
            acc_q     <= '{default: '0};
`endif
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            rate_q    <= rate_d;
            win_cnt_q <= win_cnt_d;
            spike_q   <= spike_d;
            wdone_q   <= wdone_d;
`ifdef SPIKE_ENC_POISSON_EN
            lfsr_q    <= lfsr_d;
`else
            acc_q     <= acc_d;
`endif
        end
    end
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder: a behavioural model predicts each edge's outputs,
// a monitor compares them; directed spike-count checks follow the rate-coding rules.
`timescale 1ns/1ps
module tb_spike_rate_encoder;
    localparam int WL = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_chan = '0;
    logic [7:0] in_rate = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       in_ready;
    logic [7:0] spike_out;
    logic       window_done;
    logic       busy;

    spike_rate_encoder #(.WINDOW_LEN(WL)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_rate(in_rate),
        .start(start), .stop(stop),
        .spike_out(spike_out), .window_done(window_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] spk;
        logic       wd;
        logic       bsy;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

`ifdef SPIKE_ENC_POISSON_EN
    localparam logic [7:0] SPK_MASK = 8'h00;
`else
    localparam logic [7:0] SPK_MASK = 8'hFF;
`endif

    // Behavioural model: each channel keeps the total of all rates added since start;
    // a spike occurs whenever that total crosses a multiple of 256.
    bit         m_run;
    int         m_shadow[8];
    int         m_rate[8];
    int         m_total[8];
    int         m_win;
    logic [7:0] m_spk;
    bit         m_wd;

    int cnt[8];
    int wd_cnt;
    int rdy_low;
    bit any_diff;

    task automatic model_edge();
        bit rdy;
        int old_sh[8];
        if (!rst_n) begin
            m_run = 0; m_shadow = '{default: 0}; m_rate = '{default: 0};
            m_total = '{default: 0}; m_win = 0; m_spk = '0; m_wd = 0;
        end else if (ena) begin
            rdy = !m_run || (m_win != WL - 1);
            old_sh = m_shadow;
            if (in_valid && rdy) m_shadow[in_chan] = int'(in_rate);
            m_wd = 0;
            if (!m_run) begin
                if (start && !stop) begin
                    m_run = 1; m_rate = old_sh; m_total = '{default: 0}; m_win = 0;
                end
            end else if (stop) begin
                m_run = 0; m_spk = '0; m_total = '{default: 0}; m_win = 0;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    m_spk[i] = ((m_total[i] + m_rate[i]) / 256) != (m_total[i] / 256);
                    m_total[i] += m_rate[i];
                end
                if (m_win == WL - 1) begin
                    m_win = 0; m_wd = 1; m_rate = old_sh;
                end else begin
                    m_win++;
                end
            end
        end
    endtask

    task automatic step(input bit e, input bit v, input int ch, input int r,
                        input bit st, input bit sp, input bit rs);
        exp_t x;
        @(negedge clk);
        ena = e; in_valid = v; in_chan = 3'(ch); in_rate = 8'(r);
        start = st; stop = sp; rst_n = rs;
        model_edge();
        x.spk = m_spk; x.wd = m_wd; x.bsy = m_run; x.rdy = !m_run || (m_win != WL - 1);
        exp_q.push_back(x);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) cnt[i] += int'(spike_out[i]);
        wd_cnt += int'(window_done);
        rdy_low += int'(!in_ready);
        if (spike_out != 8'h00 && spike_out != 8'hFF) any_diff = 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic clr_counts();
        cnt = '{default: 0}; wd_cnt = 0; rdy_low = 0; any_diff = 0;
    endtask

    task automatic check(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    // Monitor: compares every registered output set against the model's prediction.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk); #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (((spike_out & SPK_MASK) != (e.spk & SPK_MASK)) || window_done !== e.wd ||
                    busy !== e.bsy || in_ready !== e.rdy) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got spk=%02h wd=%0b busy=%0b rdy=%0b, expected spk=%02h wd=%0b busy=%0b rdy=%0b",
                             $time, spike_out & SPK_MASK, window_done, busy, in_ready,
                             e.spk & SPK_MASK, e.wd, e.bsy, e.rdy);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_counts();
        // Reset state
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        check("reset_spike", int'(spike_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(in_ready), 1);

`ifndef SPIKE_ENC_POISSON_EN
        // Channel 3 at rate 128 alternates, first spike on the second add.
        step(1, 1, 3, 128, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 1);
        check("ch3_start_edge", int'(spike_out[3]), 0);
        for (int k = 1; k <= 6; k++) begin
            idle(1);
            check($sformatf("ch3_add%0d", k), int'(spike_out[3]), (k % 2 == 0) ? 1 : 0);
            check($sformatf("others_add%0d", k), int'(spike_out & 8'hF7), 0);
        end
        step(1, 0, 0, 0, 0, 1, 1);
        check("stop_busy", int'(busy), 0);

        // Ramp of rates; mid-window write to ch0 waits for the boundary.
        for (int i = 0; i < 8; i++) step(1, 1, i, 32 * i, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 1);
        clr_counts();
        idle(100);
        step(1, 1, 0, 255, 0, 0, 1);
        idle(155);
        for (int i = 0; i < 8; i++) check($sformatf("win1_cnt%0d", i), cnt[i], 32 * i);
        check("win1_done", wd_cnt, 1);
        check("win1_ready_low", rdy_low, 1);
        clr_counts();
        idle(WL);
        check("win2_cnt0", cnt[0], 255);
        for (int i = 1; i < 8; i++) check($sformatf("win2_cnt%0d", i), cnt[i], 32 * i);
        check("win2_done", wd_cnt, 1);
        check("win2_ready_low", rdy_low, 1);
`else
        step(1, 0, 0, 0, 1, 0, 1);
        idle(10);
`endif

        // start+stop together: stop wins in RUN, nothing in IDLE, frozen with ena low.
        step(1, 0, 0, 0, 1, 1, 1);
        check("startstop_busy", int'(busy), 0);
        check("startstop_spike", int'(spike_out), 0);
        step(1, 0, 0, 0, 1, 1, 1);
        check("startstop_idle_busy", int'(busy), 0);
        step(1, 0, 0, 0, 1, 0, 1);
        idle(5);
        step(0, 0, 0, 0, 1, 1, 1);
        check("ena_low_busy", int'(busy), 1);
        idle(3);

        // Reset mid-run, then restart with no writes: silent.
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_spike", int'(spike_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wd", int'(window_done), 0);
        step(1, 0, 0, 0, 1, 0, 1);
        clr_counts();
        idle(300);
        for (int i = 0; i < 8; i++) check($sformatf("rst_quiet%0d", i), cnt[i], 0);
        step(1, 0, 0, 0, 0, 1, 1);

`ifdef SPIKE_ENC_POISSON_EN
        for (int i = 0; i < 8; i++) step(1, 1, i, 64, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 1);
        idle(WL);
        clr_counts();
        idle(1024);
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (cnt[i] < 208 || cnt[i] > 304) begin
                n_fail++;
                $display("FAIL poisson_cnt%0d: got %0d, expected 208..304", i, cnt[i]);
            end
        end
        check("poisson_not_identical", int'(any_diff), 1);
        step(1, 0, 0, 0, 0, 1, 1);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 499) != 0));
        end

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
